wb_lsu_master: RTL

Parametrised Wishbone classic single-access bus master between the core's load/store unit (LSU) and the system Wishbone interconnect. It replaces the fixed word-only master with:
- byte/half/word/dword accesses, byte-lane select generation, store-data steering and load sign/zero extension;
- misalignment detection, bus-error (ERR) handling and a configurable ACK timeout;
- a registered response handshake towards the LSU, with data and status.

---
 rtl/wb_pkg.sv | 21 ++
 rtl/wb_lsu_master_if.sv | 54 +++++
 rtl/wb_lane_align.sv | 55 +++++
 rtl/wb_lsu_master.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types and encodings for the Wishbone LSU master: FSM states,
// LSU access sizes and completion error codes.
package wb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUS  = 2'b01,
    RESP = 2'b10
  } state_t;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  localparam logic [1:0] EC_OK       = 2'b00;
  localparam logic [1:0] EC_MISALIGN = 2'b01;
  localparam logic [1:0] EC_BUSERR   = 2'b10;
  localparam logic [1:0] EC_TIMEOUT  = 2'b11;

endpackage

// File: rtl/wb_lsu_master_if.sv
// Signal bundle between the LSU, the Wishbone master and the interconnect.
// The master modport is the bridge's own view; slave is the environment's.
interface wb_lsu_master_if
  import wb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  localparam int SW = DATA_WIDTH / 8;

  // Wishbone classic side
  logic                  o_CYC;
  logic                  o_STB;
  logic                  o_WE;
  logic [ADDR_WIDTH-1:0] o_ADDR;
  logic [SW-1:0]         o_SEL;
  logic [DATA_WIDTH-1:0] o_DATA;
  logic [DATA_WIDTH-1:0] i_DATA;
  logic                  i_ACK;
  logic                  i_ERR;

  // LSU side: a request transfers on a cycle where i_LSU_REQ and o_LSU_READY
  // are both high; the response is valid only in the single o_LSU_DONE cycle.
  logic                  i_LSU_REQ;
  logic [ADDR_WIDTH-1:0] i_LSU_ADDR;
  logic [DATA_WIDTH-1:0] i_LSU_DATA;
  logic                  i_LSU_WE;
  logic [1:0]            i_LSU_SIZE;
  logic                  i_LSU_UNSIGNED;
  logic                  o_LSU_READY;
  logic                  o_LSU_DONE;
  logic [DATA_WIDTH-1:0] o_LSU_DATA;
  logic                  o_LSU_ERR;
  logic [1:0]            o_LSU_ECODE;

  state_t                o_STATE;

  modport master (
    output o_CYC, o_STB, o_WE, o_ADDR, o_SEL, o_DATA,
    input  i_DATA, i_ACK, i_ERR,
    input  i_LSU_REQ, i_LSU_ADDR, i_LSU_DATA, i_LSU_WE, i_LSU_SIZE, i_LSU_UNSIGNED,
    output o_LSU_READY, o_LSU_DONE, o_LSU_DATA, o_LSU_ERR, o_LSU_ECODE,
    output o_STATE
  );

  modport slave (
    input  o_CYC, o_STB, o_WE, o_ADDR, o_SEL, o_DATA,
    output i_DATA, i_ACK, i_ERR,
    output i_LSU_REQ, i_LSU_ADDR, i_LSU_DATA, i_LSU_WE, i_LSU_SIZE, i_LSU_UNSIGNED,
    input  o_LSU_READY, o_LSU_DONE, o_LSU_DATA, o_LSU_ERR, o_LSU_ECODE,
    input  o_STATE
  );

endinterface

// File: rtl/wb_lane_align.sv
// Byte-lane steering: SEL generation, store data placement, alignment check
// and load data extraction with sign/zero extension.
module wb_lane_align
  import wb_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  localparam int SW         = DATA_WIDTH / 8,
  localparam int OW         = $clog2(SW)
) (
  input  logic [OW-1:0]         i_off,
  input  logic [1:0]            i_size,
  input  logic                  i_unsigned,
  input  logic [DATA_WIDTH-1:0] i_store,
  input  logic [DATA_WIDTH-1:0] i_load_raw,
  output logic [SW-1:0]         o_sel,
  output logic [DATA_WIDTH-1:0] o_wdata,
  output logic                  o_misalign,
  output logic [DATA_WIDTH-1:0] o_load
);

  int                    off_i;
  int                    nb_req;
  int                    nb_load;
  logic                  sign;
  logic [DATA_WIDTH-1:0] shifted_st;
  logic [DATA_WIDTH-1:0] shifted_ld;

  always_comb begin
    off_i   = int'(i_off);
    nb_req  = 1 << i_size;
    // A dword on a 32-bit bus is flagged misaligned; clamp so the sign bit index stays in range.
    nb_load = (nb_req > SW) ? SW : nb_req;

    case (i_size)
      SZ_H:    o_misalign = (off_i % 2) != 0;
      SZ_W:    o_misalign = (off_i % 4) != 0;
      SZ_D:    o_misalign = (DATA_WIDTH < 64) || ((off_i % 8) != 0);
      default: o_misalign = 1'b0;
    endcase

    shifted_st = i_store << (8 * off_i);
    shifted_ld = i_load_raw >> (8 * off_i);
    sign       = ~i_unsigned & shifted_ld[8*nb_load-1];

    o_sel   = '0;
    o_wdata = '0;
    o_load  = '0;
    for (int i = 0; i < SW; i++) begin
      o_sel[i]         = (i >= off_i) && (i < off_i + nb_req);
      o_wdata[8*i +: 8] = o_sel[i] ? shifted_st[8*i +: 8] : 8'h00;
      o_load[8*i +: 8]  = (i < nb_load) ? shifted_ld[8*i +: 8] : {8{sign}};
    end
  end

endmodule

// File: rtl/wb_lsu_master.sv
// Wishbone classic single-access master for the LSU: one access per
// IDLE -> BUS -> RESP pass, with alignment, bus-error and timeout reporting.
module wb_lsu_master
  import wb_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic           i_CLK,
  input logic           i_RST,
  wb_lsu_master_if.master bus
);

  localparam int SW = DATA_WIDTH / 8;
  localparam int OW = $clog2(SW);
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [SW-1:0]         sel_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  we_q;
  logic [OW-1:0]         off_q;
  logic [1:0]            size_q;
  logic                  uns_q;
  logic [1:0]            ecode_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [CW-1:0]         cnt_q;

  logic [OW-1:0]         al_off;
  logic [1:0]            al_size;
  logic                  al_uns;
  logic [SW-1:0]         al_sel;
  logic [DATA_WIDTH-1:0] al_wdata;
  logic                  al_misalign;
  logic [DATA_WIDTH-1:0] al_load;

  logic accept;
  logic timeout_hit;

  // The aligner sees the live request in IDLE and the latched access afterwards.
  always_comb begin
    if (state_q == IDLE) begin
      al_off  = bus.i_LSU_ADDR[OW-1:0];
      al_size = bus.i_LSU_SIZE;
      al_uns  = bus.i_LSU_UNSIGNED;
    end else begin
      al_off  = off_q;
      al_size = size_q;
      al_uns  = uns_q;
    end
  end

  wb_lane_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .i_off      (al_off),
    .i_size     (al_size),
    .i_unsigned (al_uns),
    .i_store    (bus.i_LSU_DATA),
    .i_load_raw (bus.i_DATA),
    .o_sel      (al_sel),
    .o_wdata    (al_wdata),
    .o_misalign (al_misalign),
    .o_load     (al_load)
  );

  assign accept      = bus.i_LSU_REQ && (state_q == IDLE);
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_CLK) begin
    if (i_RST) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = al_misalign ? RESP : BUS;
      BUS:     if (bus.i_ERR || bus.i_ACK || timeout_hit) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Access latch and completion status; ERR outranks ACK, ACK outranks timeout.
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      addr_q  <= '0;
      sel_q   <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      off_q   <= '0;
      size_q  <= SZ_B;
      uns_q   <= 1'b0;
      ecode_q <= EC_OK;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            addr_q  <= {bus.i_LSU_ADDR[ADDR_WIDTH-1:OW], {OW{1'b0}}};
            sel_q   <= al_sel;
            wdata_q <= al_wdata;
            we_q    <= bus.i_LSU_WE;
            off_q   <= bus.i_LSU_ADDR[OW-1:0];
            size_q  <= bus.i_LSU_SIZE;
            uns_q   <= bus.i_LSU_UNSIGNED;
            cnt_q   <= '0;
            rdata_q <= '0;
            ecode_q <= al_misalign ? EC_MISALIGN : EC_OK;
          end
        end
        BUS: begin
          cnt_q <= cnt_q + 1'b1;
          if (bus.i_ERR) begin
            ecode_q <= EC_BUSERR;
          end else if (bus.i_ACK) begin
            ecode_q <= EC_OK;
            rdata_q <= we_q ? '0 : al_load;
          end else if (timeout_hit) begin
            ecode_q <= EC_TIMEOUT;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.o_CYC       = (state_q == BUS);
    bus.o_STB       = (state_q == BUS);
    bus.o_WE        = (state_q == BUS) && we_q;
    bus.o_ADDR      = (state_q == BUS) ? addr_q  : '0;
    bus.o_SEL       = (state_q == BUS) ? sel_q   : '0;
    bus.o_DATA      = (state_q == BUS) ? wdata_q : '0;
    bus.o_LSU_READY = (state_q == IDLE);
    bus.o_LSU_DONE  = (state_q == RESP);
    bus.o_LSU_DATA  = (state_q == RESP) ? rdata_q : '0;
    bus.o_LSU_ERR   = (state_q == RESP) && (ecode_q != EC_OK);
    bus.o_LSU_ECODE = (state_q == RESP) ? ecode_q : EC_OK;
    bus.o_STATE     = state_q;
  end

endmodule
